// File: rtl/cfs_md_rx_pkg.sv
// Shared definitions for the multi-channel MD RX controller: width helpers,
// push_data field positions and the transfer legality rule.
package cfs_md_rx_pkg;

    function automatic int offset_w(input int dw);
        return (dw <= 8) ? 1 : $clog2(dw / 8);
    endfunction

    function automatic int size_w(input int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // push_data = {size, offset, data}; size sits in the MSBs
    function automatic int data_lsb(input int dw);
        return 0;
    endfunction

    function automatic int data_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int offset_lsb(input int dw);
        return dw;
    endfunction

    function automatic int offset_msb(input int dw);
        return dw + offset_w(dw) - 1;
    endfunction

    function automatic int size_lsb(input int dw);
        return dw + offset_w(dw);
    endfunction

    function automatic int size_msb(input int dw);
        return dw + offset_w(dw) + size_w(dw) - 1;
    endfunction

    // Same rule as the TX side: non-zero size, aligned offset, no overrun of the bus word
    function automatic logic is_legal(input int unsigned bytes,
                                      input int unsigned offset,
                                      input int unsigned size);
        logic ok;
        if (size == 32'd0) begin
            ok = 1'b0;
        end else if (((bytes + offset) % size) != 32'd0) begin
            ok = 1'b0;
        end else if ((offset + size) > bytes) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/cfs_md_rx_ctrl_mc_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// freezes that grant while the downstream push is stalled.
module cfs_rr_arb
    import cfs_md_rx_pkg::*;
#(
    parameter int N = 2,
    localparam int CW = ch_w(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant,
    output logic [CW-1:0] o_grant_idx
);

    logic [CW-1:0]  r_ptr;
    logic           r_lock_vld;
    logic [CW-1:0]  r_lock_idx;
    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    int             w_k;
    int             w_sum;
    logic [CW-1:0]  w_search_idx;

    // Rotate requests so the pointer sits at bit 0, then take the lowest set bit
    always_comb begin
        w_req2 = {i_req, i_req};
        w_rot  = N'(w_req2 >> r_ptr);
        w_k    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_k = w_rot[k] ? k : w_k;
        end
        w_sum        = int'(r_ptr) + w_k;
        w_search_idx = (w_sum >= N) ? CW'(w_sum - N) : CW'(w_sum);
    end

    // A grant issued during a stall is held until its handshake completes
    always_comb begin
        o_grant_idx = r_lock_vld ? r_lock_idx : w_search_idx;
        o_grant     = '0;
        for (int k = 0; k < N; k++) begin
            o_grant[k] = (int'(o_grant_idx) == k) & (|i_req);
        end
    end

    // Pointer moves past the winner only on a completed push
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else if (i_advance) begin
            r_ptr      <= (int'(o_grant_idx) == N - 1) ? '0 : o_grant_idx + CW'(1);
            r_lock_vld <= 1'b0;
            r_lock_idx <= r_lock_idx;
        end else begin
            r_ptr      <= r_ptr;
            r_lock_vld <= |i_req;
            r_lock_idx <= o_grant_idx;
        end
    end

endmodule

// File: rtl/cfs_md_rx_ctrl_mc.sv
// Multi-channel MD RX controller: per-channel legality check, 1-entry hold,
// saturating drop counters and round-robin merge onto one FIFO push port.
module cfs_md_rx_ctrl_mc
    import cfs_md_rx_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH       = 32,
    parameter int NUM_CH                = 2,
    parameter int STATUS_CNT_DROP_WIDTH = 8,
    localparam int OFFSET_W        = offset_w(ALGN_DATA_WIDTH),
    localparam int SIZE_W          = size_w(ALGN_DATA_WIDTH),
    localparam int CH_W            = ch_w(NUM_CH),
    localparam int FIFO_DATA_WIDTH = ALGN_DATA_WIDTH + OFFSET_W + SIZE_W
) (
    input  logic                                    pclk,
    input  logic                                    preset,
    input  logic                                    drop_on_full,
    input  logic [NUM_CH-1:0]                       clr_cnt_drop,
    output logic [NUM_CH*STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
    input  logic [NUM_CH-1:0]                       md_rx_valid,
    input  logic [NUM_CH*ALGN_DATA_WIDTH-1:0]       md_rx_data,
    input  logic [NUM_CH*OFFSET_W-1:0]              md_rx_offset,
    input  logic [NUM_CH*SIZE_W-1:0]                md_rx_size,
    output logic [NUM_CH-1:0]                       md_rx_ready,
    output logic [NUM_CH-1:0]                       md_rx_err,
    output logic                                    push_valid,
    output logic [FIFO_DATA_WIDTH-1:0]              push_data,
    output logic [CH_W-1:0]                         push_ch,
    input  logic                                    push_ready
);

    localparam int unsigned BYTES = ALGN_DATA_WIDTH / 8;
    localparam int CW = STATUS_CNT_DROP_WIDTH;

    logic [NUM_CH-1:0]                 w_hold_valid;
    logic [NUM_CH-1:0]                 w_err;
    logic [NUM_CH-1:0]                 w_ready;
    logic [NUM_CH-1:0]                 w_fire;
    logic [NUM_CH-1:0]                 w_clear;
    logic [NUM_CH-1:0]                 w_grant;
    logic [CH_W-1:0]                   w_grant_idx;
    logic [NUM_CH*FIFO_DATA_WIDTH-1:0] w_hold_flat;
    logic                              w_push_valid;
    logic                              w_advance;

    assign w_push_valid = ~preset & (|w_hold_valid);
    assign w_advance    = w_push_valid & push_ready;

    cfs_rr_arb #(.N(NUM_CH)) u_arb (
        .i_clk       (pclk),
        .i_rst       (preset),
        .i_req       (w_hold_valid),
        .i_advance   (w_advance),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ALGN_DATA_WIDTH-1:0] w_data;
        logic [OFFSET_W-1:0]        w_off;
        logic [SIZE_W-1:0]          w_size;
        logic                       w_legal;
        logic                       r_hold_valid;
        logic [FIFO_DATA_WIDTH-1:0] r_hold_data;
        logic [CW-1:0]              r_cnt;

        assign w_data  = md_rx_data[c*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
        assign w_off   = md_rx_offset[c*OFFSET_W +: OFFSET_W];
        assign w_size  = md_rx_size[c*SIZE_W +: SIZE_W];
        assign w_legal = is_legal(BYTES, 32'(w_off), 32'(w_size));

        // Ready never depends on push_ready, so a freed hold refills one cycle later
        assign w_err[c]   = ~preset & md_rx_valid[c] & ~w_legal;
        assign w_ready[c] = ~preset & (w_err[c] | ~r_hold_valid
                                      | (drop_on_full & r_hold_valid & md_rx_valid[c]));
        assign w_fire[c]  = md_rx_valid[c] & w_ready[c];
        assign w_clear[c] = w_advance & w_grant[c];

        // Holding register: capture a legal transfer only into an empty slot
        always_ff @(posedge pclk) begin
            if (preset) begin
                r_hold_valid <= 1'b0;
                r_hold_data  <= '0;
            end else if (w_fire[c] & w_legal & ~r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= {w_size, w_off, w_data};
            end else if (w_clear[c]) begin
                r_hold_valid <= 1'b0;
                r_hold_data  <= r_hold_data;
            end else begin
                r_hold_valid <= r_hold_valid;
                r_hold_data  <= r_hold_data;
            end
        end

        // Drop counter: illegal transfers and legal ones accepted while full
        always_ff @(posedge pclk) begin
            if (preset) begin
                r_cnt <= '0;
            end else if (clr_cnt_drop[c]) begin
                r_cnt <= '0;
            end else if (w_fire[c] & (~w_legal | r_hold_valid) & (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end

        assign w_hold_valid[c]                                         = r_hold_valid;
        assign w_hold_flat[c*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH]       = r_hold_data;
        assign status_cnt_drop[c*CW +: CW]                             = r_cnt;
    end

    assign md_rx_ready = w_ready;
    assign md_rx_err   = w_err;
    assign push_valid  = w_push_valid;
    assign push_ch     = w_grant_idx;
    assign push_data   = w_hold_flat[w_grant_idx*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];

endmodule
